// File: rtl/axi_mm_arbiter.sv
// rtl/axi_mm_arbiter.sv - two-requester round-robin arbiter issuing one AXI AW/AR burst and tracking its response
// Optional watchdog abort is built in when AXI_ARB_TIMEOUT_EN is defined.
module axi_mm_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_wr0,
  input  logic              i_wr1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [7:0]        i_len0,
  input  logic [7:0]        i_len1,
  output logic [1:0]        o_gnt,
  output logic [1:0]        o_done,
  output logic              o_err,
  output logic              o_m_axi_awvalid,
  output logic [ADDR_W-1:0] o_m_axi_awaddr,
  output logic [7:0]        o_m_axi_awlen,
  input  logic              i_m_axi_awready,
  output logic              o_m_axi_arvalid,
  output logic [ADDR_W-1:0] o_m_axi_araddr,
  output logic [7:0]        o_m_axi_arlen,
  input  logic              i_m_axi_arready,
  input  logic              i_m_axi_bvalid,
  input  logic              i_m_axi_bready,
  input  logic              i_m_axi_rvalid,
  input  logic              i_m_axi_rready,
  input  logic              i_m_axi_rlast
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..65535");
  end

  state_t            r_state, w_state;
  logic [1:0]        r_gnt, w_gnt, r_done, w_done;
  logic              r_err, w_err;
  logic              r_awvalid, w_awvalid, r_arvalid, w_arvalid;
  logic              r_wr, w_wr, r_last, w_last, r_armed;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [7:0]        r_len, w_len;
  logic              w_win1, w_addr_hs, w_resp_done;

  // r_last holds the index of the last granted requester; the other one wins a tie
  assign w_win1      = i_req1 && (!i_req0 || !r_last);
  assign w_addr_hs   = (r_awvalid && i_m_axi_awready) || (r_arvalid && i_m_axi_arready);
  assign w_resp_done = r_wr ? (i_m_axi_bvalid && i_m_axi_bready)
                            : (i_m_axi_rvalid && i_m_axi_rready && i_m_axi_rlast);

`ifdef AXI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt, w_cnt;
`endif

  always_comb begin
    w_state   = r_state;
    w_gnt     = r_gnt;
    w_done    = 2'b00;
    w_err     = 1'b0;
    w_awvalid = r_awvalid;
    w_arvalid = r_arvalid;
    w_wr      = r_wr;
    w_last    = r_last;
    w_addr    = r_addr;
    w_len     = r_len;
`ifdef AXI_ARB_TIMEOUT_EN
    w_cnt     = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_armed && (i_req0 || i_req1)) begin
          w_last    = w_win1;
          w_gnt     = w_win1 ? 2'b10 : 2'b01;
          w_wr      = w_win1 ? i_wr1 : i_wr0;
          w_addr    = w_win1 ? i_addr1 : i_addr0;
          w_len     = w_win1 ? i_len1 : i_len0;
          w_awvalid = w_wr;
          w_arvalid = !w_wr;
          w_state   = S_ADDR;
`ifdef AXI_ARB_TIMEOUT_EN
          w_cnt     = 16'd0;
`endif
        end
      end
      S_ADDR: begin
        if (w_addr_hs) begin
          w_awvalid = 1'b0;
          w_arvalid = 1'b0;
          w_state   = S_RESP;
        end
      end
      S_RESP: begin
        if (w_resp_done) begin
          w_done  = r_gnt;
          w_gnt   = 2'b00;
          w_state = S_DONE;
        end
      end
      default: w_state = S_IDLE;
    endcase
`ifdef AXI_ARB_TIMEOUT_EN
    // A genuine completion on the final watchdog cycle is reported as success
    if (r_state == S_ADDR || r_state == S_RESP) begin
      w_cnt = r_cnt + 16'd1;
      if (r_cnt == TMO_LAST && !(r_state == S_RESP && w_resp_done)) begin
        w_awvalid = 1'b0;
        w_arvalid = 1'b0;
        w_done    = r_gnt;
        w_err     = 1'b1;
        w_gnt     = 2'b00;
        w_state   = S_DONE;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_err     <= 1'b0;
      r_awvalid <= 1'b0;
      r_arvalid <= 1'b0;
      r_wr      <= 1'b0;
      r_last    <= 1'b1;
      r_armed   <= 1'b0;
      r_addr    <= '0;
      r_len     <= 8'd0;
`ifdef AXI_ARB_TIMEOUT_EN
      r_cnt     <= 16'd0;
`endif
    end else begin
      r_state   <= w_state;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_err     <= w_err;
      r_awvalid <= w_awvalid;
      r_arvalid <= w_arvalid;
      r_wr      <= w_wr;
      r_last    <= w_last;
      r_armed   <= 1'b1;
      r_addr    <= w_addr;
      r_len     <= w_len;
`ifdef AXI_ARB_TIMEOUT_EN
      r_cnt     <= w_cnt;
`endif
    end
  end

  assign o_gnt           = r_gnt;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_m_axi_awvalid = r_awvalid;
  assign o_m_axi_arvalid = r_arvalid;
  assign o_m_axi_awaddr  = r_addr;
  assign o_m_axi_araddr  = r_addr;
  assign o_m_axi_awlen   = r_len;
  assign o_m_axi_arlen   = r_len;

endmodule
